// File: rtl/mdu_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
package mdu_pkg;

    localparam int MDU_DATA_W = 32;
    localparam int DIV_CYCLES = MDU_DATA_W + 1;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } mdu_state_e;

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract.
module mdu_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quo,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] quo_next
);

    // One extra bit: the shifted remainder can exceed DATA_W bits for large divisors.
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;
    logic            fits;

    always_comb begin
        shifted  = {rem, quo[DATA_W-1]};
        diff     = shifted - {1'b0, divisor};
        fits     = ~diff[DATA_W];
        rem_next = fits ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
        quo_next = {quo[DATA_W-2:0], fits};
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; stalls issue via busy_o while in flight.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_W     = MDU_DATA_W,
    parameter int MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] src_a_i,
    input  logic [DATA_W-1:0] src_b_i,
    input  logic              flush_ex_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CNT_W = $clog2(DATA_W + 2);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] a_q, b_q, rem_q;
    logic              sgn_q, neg_q_q, neg_r_q, dz_q;
    logic [DATA_W-1:0] hi_q, lo_q;
    logic              done_q;

    logic              accept, is_mul_op, is_div_op;
    logic              sgn, a_neg, b_neg;
    logic [DATA_W-1:0] a_abs, b_abs;
    logic              mul_last, div_last;

    always_comb begin
        accept    = op_valid_i && !flush_ex_i && (state_q == IDLE);
        is_mul_op = (op_i == MDU_MULT) || (op_i == MDU_MULTU);
        is_div_op = (op_i == MDU_DIV) || (op_i == MDU_DIVU);
        sgn       = is_signed_op(op_i);
        a_neg     = sgn & src_a_i[DATA_W-1];
        b_neg     = sgn & src_b_i[DATA_W-1];
        a_abs     = a_neg ? -src_a_i : src_a_i;
        b_abs     = b_neg ? -src_b_i : src_b_i;
        mul_last  = (cnt_q == CNT_W'(MUL_CYCLES - 1));
        div_last  = (cnt_q == CNT_W'(DATA_W));
    end

    // Extending to 2*DATA_W gives the exact low 2*DATA_W product bits for both signednesses.
    logic [2*DATA_W-1:0] mul_a, mul_b, product;
    always_comb begin
        mul_a   = {{DATA_W{sgn_q & a_q[DATA_W-1]}}, a_q};
        mul_b   = {{DATA_W{sgn_q & b_q[DATA_W-1]}}, b_q};
        product = mul_a * mul_b;
    end

    logic [DATA_W-1:0] rem_nx, quo_nx, q_fix, r_fix;

    mdu_div_step #(.DATA_W(DATA_W)) u_div_step (
        .rem      (rem_q),
        .quo      (a_q),
        .divisor  (b_q),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    always_comb begin
        q_fix = neg_q_q ? -a_q : a_q;
        r_fix = neg_r_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && is_mul_op)      state_d = MUL;
                else if (accept && is_div_op) state_d = DIV;
            end
            MUL:     if (mul_last) state_d = IDLE;
            DIV:     if (div_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            sgn_q   <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_q <= '0;
                        case (op_i)
                            MDU_MTHI: hi_q <= src_a_i;
                            MDU_MTLO: lo_q <= src_a_i;
                            MDU_MULT, MDU_MULTU: begin
                                a_q   <= src_a_i;
                                b_q   <= src_b_i;
                                sgn_q <= sgn;
                            end
                            MDU_DIV, MDU_DIVU: begin
                                a_q     <= a_abs;
                                b_q     <= b_abs;
                                rem_q   <= '0;
                                neg_q_q <= a_neg ^ b_neg;
                                neg_r_q <= a_neg;
                                dz_q    <= (src_b_i == '0);
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (mul_last) begin
                        hi_q   <= product[2*DATA_W-1:DATA_W];
                        lo_q   <= product[DATA_W-1:0];
                        done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DIV: begin
                    if (div_last) begin
                        // Divide by zero leaves |dividend| in rem; r_fix restores the original.
                        lo_q   <= dz_q ? '1 : q_fix;
                        hi_q   <= r_fix;
                        done_q <= 1'b1;
                    end else begin
                        a_q   <= quo_nx;
                        rem_q <= rem_nx;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the MIPS pipeline; owns the HI/LO architectural registers.
- Operands arrive already selected by the EX forwarding muxes, which are steered by the hazard unit's fwd_p1/fwd_p2 outputs.
- busy_o feeds the hazard unit so it can stall fetch/issue while an operation is in flight.
- hi_o/lo_o feed the EX result mux for MFHI/MFLO.

Parameters:
- DATA_W, 32, operand and HI/LO width.
- MUL_CYCLES, 4, busy cycles for MULT/MULTU; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- op_valid_i  input  1  EX-stage instruction is an MDU op
- op_i  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, others=no-op
- src_a_i  input  DATA_W  forwarded rs value (multiplicand/dividend/MTxx data)
- src_b_i  input  DATA_W  forwarded rt value (multiplier/divisor)
- flush_ex_i  input  1  hazard-unit flush of the EX instruction
- busy_o  output  1  operation in flight; request stall
- done_o  output  1  one-cycle pulse; HI/LO just updated by MUL/DIV
- hi_o  output  DATA_W  HI register
- lo_o  output  DATA_W  LO register

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high; it is sampled on the rising edge of clk.
- Reset values: state=IDLE, hi_o=0, lo_o=0, busy_o=0, done_o=0, counter=0.
- Reset mid-operation aborts the operation; HI/LO take the reset value 0, not the result.
- Accept rule: op accepted at edge E0 iff op_valid_i & !flush_ex_i & !busy_o & !reset.
- A flushed op is discarded with no side effects.
- op_valid_i while busy_o=1 is ignored; the hazard unit must hold the instruction.
- MTHI/MTLO: HI or LO = src_a_i at E0; busy_o never asserted; no done_o.
- Undefined op codes (6, 7): no-op.
- FSM states and transitions:
  - IDLE -> MUL on accepted MULT/MULTU; IDLE -> DIV on accepted DIV/DIVU.
  - MUL -> IDLE after MUL_CYCLES cycles; DIV -> IDLE after DATA_W+1 cycles.
- Operand latching: operands and signedness are latched at E0. Later changes on src_*_i have no effect.
- busy_o: 1 from the cycle after E0 until the completion edge, inclusive of the last busy cycle; 0 in IDLE.
- MUL timing: 2*DATA_W-bit product written HI=upper, LO=lower at edge E0+MUL_CYCLES. busy_o high for exactly MUL_CYCLES cycles. done_o high in the cycle after the write.
- MULT vs MULTU: MULT is signed x signed; MULTU is unsigned x unsigned.
- DIV algorithm:
  - Edge E0 latches the absolute values (signed case) or raw values (unsigned case).
  - Edges E1..E32 each perform one restoring step: shift remainder/quotient left, trial-subtract, set the quotient bit.
  - Edge E33 applies the sign fix and writes LO=quotient, HI=remainder.
  - busy_o is high for DATA_W+1 = 33 cycles.
- DIV sign rules: quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (both DIV and DIVU): same 33-cycle latency; result LO=all ones, HI=dividend.
- Overflow case -2^31 / -1 (signed): LO=0x80000000, HI=0.
- done_o and busy_o never high in the same cycle.
- A new op may be accepted in the cycle where done_o=1.
- flush_ex_i while busy_o=1 does not affect the in-flight op. That op belongs to an older instruction.
- hi_o/lo_o are register outputs; no combinational path from inputs.

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO
  - FSM state encoding: IDLE, MUL, DIV
  - DIV_CYCLES = DATA_W+1
- One sub-module: mdu_div_step.
  - Combinational single restoring-divide iteration.
  - Inputs: remainder, quotient, divisor. Outputs: next remainder, next quotient.
- The top level holds the FSM, counter, operand/sign registers, product pipeline and HI/LO.

Test Plan:
- MULT 7 x 0xFFFFFFFD (-3): busy_o high 4 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB, done_o 1 cycle.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 4 cycles.
- DIV 0xFFFFFFF9 (-7) / 2: busy_o 33 cycles -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x64 / 0 -> LO=0xFFFFFFFF, HI=0x64 after 33 cycles.
- Handshake and side-effect cases:
  - op_valid_i with flush_ex_i=1 -> no state change.
  - MTLO 0x1234 while busy -> ignored.
  - MTHI 0xABCD in IDLE -> hi_o=0xABCD next cycle, busy_o stays 0.
- Reset asserted at cycle 10 of a DIV -> next cycle busy_o=0, HI=LO=0, done_o never pulses. A following MULT 3x5 gives LO=15 after 4 cycles.
